// File: rtl/mips_mem_arbiter_if.sv
// Signal bundle between the MIPS memory arbiter, its three requesters and the Avalon slave.
// master: arbiter view (drives the Avalon command). slave: environment view (requesters + memory).
interface mips_mem_arbiter_if;
    // instruction read port
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    // data read port
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_byteenable;
    logic [31:0] d_rdata;
    logic        d_ack;
    // write buffer drain port
    logic        wb_write;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_byteenable;
    logic        wb_empty;
    logic        wb_full;
    logic        wb_waitrequest;
    // Avalon-MM master
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_addr, d_byteenable,
        output d_rdata, d_ack,
        input  wb_write, wb_addr, wb_wdata, wb_byteenable, wb_empty, wb_full,
        output wb_waitrequest,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_addr, d_byteenable,
        input  d_rdata, d_ack,
        output wb_write, wb_addr, wb_wdata, wb_byteenable, wb_empty, wb_full,
        input  wb_waitrequest,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Arbitrates instruction fetch, data reads and write-buffer drain onto one Avalon master.
// Optional macro MIPS_ARB_RR_EN: round-robin between data and instruction reads on a tie.
module mips_mem_arbiter (
    input  logic               clk,
    input  logic               rst,
    mips_mem_arbiter_if.master bus,
    output logic [1:0]         grant_state
);

    // Handshake: a requester raises req (or wb_write) and holds req/addr/data stable until
    // its ack (wb_waitrequest low); a grant is made only from IDLE, the Avalon command is
    // issued the following cycle and completes in the first cycle with avm_waitrequest low,
    // when ack and read data are returned combinationally. The arbiter then revisits IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_WB = 2'd1,
        GNT_D  = 2'd2,
        GNT_I  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic wb_urgent;
    logic d_eligible;
    logic i_eligible;
    logic d_wins_tie;
    logic bus_cmd;
    logic xfer_done;

    // A data read may only pass once the write buffer is empty (read-after-write order).
    assign wb_urgent  = bus.wb_write & bus.wb_full;
    assign d_eligible = bus.d_req & bus.wb_empty;
    assign i_eligible = bus.i_req;

`ifdef MIPS_ARB_RR_EN
    logic favour_i_q;

    // Set after a data read completes, cleared after an instruction read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            favour_i_q <= 1'b0;
        end else if (xfer_done && (state_q == GNT_D)) begin
            favour_i_q <= 1'b1;
        end else if (xfer_done && (state_q == GNT_I)) begin
            favour_i_q <= 1'b0;
        end
    end

    assign d_wins_tie = ~favour_i_q;
`else
    assign d_wins_tie = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wb_urgent) begin
                    state_d = GNT_WB;
                end else if (d_eligible && i_eligible) begin
                    state_d = d_wins_tie ? GNT_D : GNT_I;
                end else if (d_eligible) begin
                    state_d = GNT_D;
                end else if (i_eligible) begin
                    state_d = GNT_I;
                end else if (bus.wb_write) begin
                    state_d = GNT_WB;
                end
            end
            GNT_WB: begin
                // The buffer may run dry while granted; give the bus back without writing.
                if (!bus.wb_write || xfer_done) begin
                    state_d = IDLE;
                end
            end
            GNT_D, GNT_I: begin
                if (xfer_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Avalon command is steered straight from the granted port.
    always_comb begin
        bus.avm_address    = 32'h0;
        bus.avm_read       = 1'b0;
        bus.avm_write      = 1'b0;
        bus.avm_writedata  = 32'h0;
        bus.avm_byteenable = 4'h0;
        unique case (state_q)
            GNT_WB: begin
                bus.avm_address    = bus.wb_addr;
                bus.avm_write      = bus.wb_write;
                bus.avm_writedata  = bus.wb_wdata;
                bus.avm_byteenable = bus.wb_byteenable;
            end
            GNT_D: begin
                bus.avm_address    = bus.d_addr;
                bus.avm_read       = 1'b1;
                bus.avm_byteenable = bus.d_byteenable;
            end
            GNT_I: begin
                bus.avm_address    = bus.i_addr;
                bus.avm_read       = 1'b1;
                bus.avm_byteenable = 4'hF;
            end
            default: begin
            end
        endcase
    end

    // A transaction interrupted by reset is abandoned, so no completion is reported then.
    assign bus_cmd   = bus.avm_read | bus.avm_write;
    assign xfer_done = bus_cmd & ~bus.avm_waitrequest & ~rst;

    always_comb begin
        bus.i_ack          = 1'b0;
        bus.i_rdata        = 32'h0;
        bus.d_ack          = 1'b0;
        bus.d_rdata        = 32'h0;
        bus.wb_waitrequest = 1'b1;
        if (xfer_done) begin
            unique case (state_q)
                GNT_I: begin
                    bus.i_ack   = 1'b1;
                    bus.i_rdata = bus.avm_readdata;
                end
                GNT_D: begin
                    bus.d_ack   = 1'b1;
                    bus.d_rdata = bus.avm_readdata;
                end
                GNT_WB: begin
                    bus.wb_waitrequest = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign grant_state = state_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios plus random traffic against a cycle reference model.
// Build with MIPS_ARB_RR_EN defined to exercise the round-robin tie-break expectations.
module tb_mips_mem_arbiter;

    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_state;

    mips_mem_arbiter_if bus ();

    mips_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_state (grant_state)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: who holds the bus (0 nobody, 1 write buffer, 2 data, 3 instruction)
    bit  model_on    = 1'b0;
    int  owner       = 0;
    bit  rr_favour_i = 1'b0;

    function automatic int pick_grant();
        bit d_ok;
        d_ok = bus.d_req && bus.wb_empty;
        if (bus.wb_write && bus.wb_full) return 1;
        if (d_ok && bus.i_req) begin
`ifdef MIPS_ARB_RR_EN
            return rr_favour_i ? 3 : 2;
`else
            return 2;
`endif
        end
        if (d_ok)         return 2;
        if (bus.i_req)    return 3;
        if (bus.wb_write) return 1;
        return 0;
    endfunction

    function automatic bit model_done();
        bit cmd;
        cmd = (owner == 2) || (owner == 3) || ((owner == 1) && bus.wb_write);
        return cmd && !bus.avm_waitrequest && !rst;
    endfunction

    task automatic model_check();
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        bit          done;
        e_addr = 32'h0;
        e_wd   = 32'h0;
        e_be   = 4'h0;
        case (owner)
            1: begin e_addr = bus.wb_addr; e_wd = bus.wb_wdata; e_be = bus.wb_byteenable; end
            2: begin e_addr = bus.d_addr;  e_be = bus.d_byteenable; end
            3: begin e_addr = bus.i_addr;  e_be = 4'hF; end
            default: begin end
        endcase
        done = model_done();
        check("grant_state", grant_state, owner[1:0]);
        check("avm_read", bus.avm_read, (owner == 2) || (owner == 3));
        check("avm_write", bus.avm_write, (owner == 1) && bus.wb_write);
        check("avm_address", bus.avm_address, e_addr);
        check("avm_byteenable", bus.avm_byteenable, e_be);
        check("avm_writedata", bus.avm_writedata, e_wd);
        check("i_ack", bus.i_ack, done && (owner == 3));
        check("i_rdata", bus.i_rdata, (done && (owner == 3)) ? bus.avm_readdata : 32'h0);
        check("d_ack", bus.d_ack, done && (owner == 2));
        check("d_rdata", bus.d_rdata, (done && (owner == 2)) ? bus.avm_readdata : 32'h0);
        check("wb_waitrequest", bus.wb_waitrequest, !(done && (owner == 1)));
    endtask

    always @(negedge clk) begin
        if (model_on) model_check();
    end

    always @(posedge clk) begin
        if (model_on) begin
            if (rst) begin
                owner       = 0;
                rr_favour_i = 1'b0;
            end else if (owner == 0) begin
                owner = pick_grant();
            end else if (model_done()) begin
                if (owner == 2) rr_favour_i = 1'b1;
                if (owner == 3) rr_favour_i = 1'b0;
                owner = 0;
            end else if ((owner == 1) && !bus.wb_write) begin
                owner = 0;
            end
        end
    end

    // ---------------- requesters, scoreboard, stepping ----------------
    wb_entry_t   wb_q[$];
    logic [33:0] exp_q[$];      // {grant kind, address} of each expected completion, in order
    bit          sb_on       = 1'b1;
    bit          random_mode = 1'b0;

    logic [1:0]  s_gs;
    logic        s_read, s_write, s_iack, s_dack, s_wbwait;
    logic [31:0] s_addr, s_irdata;

    task automatic apply_wb();
        if (wb_q.size() > 0) begin
            bus.wb_write      = 1'b1;
            bus.wb_addr       = wb_q[0].addr;
            bus.wb_wdata      = wb_q[0].data;
            bus.wb_byteenable = wb_q[0].be;
        end else begin
            bus.wb_write      = 1'b0;
            bus.wb_addr       = 32'h0;
            bus.wb_wdata      = 32'h0;
            bus.wb_byteenable = 4'h0;
        end
        bus.wb_empty = (wb_q.size() == 0);
        bus.wb_full  = (wb_q.size() == WB_DEPTH);
    endtask

    task automatic push_wb(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wb_entry_t e;
        e.addr = addr;
        e.data = data;
        e.be   = be;
        wb_q.push_back(e);
    endtask

    task automatic issue_i(input logic [31:0] addr);
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
    endtask

    task automatic issue_d(input logic [31:0] addr, input logic [3:0] be);
        bus.d_req        = 1'b1;
        bus.d_addr       = addr;
        bus.d_byteenable = be;
    endtask

    // Snapshot the current cycle mid-period, then advance to just after the next edge.
    task automatic step();
        logic [33:0] exp_e;
        @(negedge clk);
        s_gs     = grant_state;
        s_read   = bus.avm_read;
        s_write  = bus.avm_write;
        s_addr   = bus.avm_address;
        s_iack   = bus.i_ack;
        s_irdata = bus.i_rdata;
        s_dack   = bus.d_ack;
        s_wbwait = bus.wb_waitrequest;
        if (sb_on && (s_iack || s_dack || !s_wbwait)) begin
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
            check("sb_order", {s_gs, s_addr}, exp_e);
        end
        @(posedge clk);
        #1;
        if (s_iack) bus.i_req = 1'b0;
        if (s_dack) bus.d_req = 1'b0;
        if (!s_wbwait && (wb_q.size() > 0)) wb_q.delete(0);
        if (random_mode) begin
            if (!bus.i_req && ($urandom_range(0, 3) == 0)) issue_i($urandom() & 32'hFFFF_FFFC);
            if (!bus.d_req && ($urandom_range(0, 3) == 0))
                issue_d($urandom() & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)));
            if ((wb_q.size() < WB_DEPTH) && ($urandom_range(0, 2) == 0))
                push_wb($urandom() & 32'hFFFF_FFFC, $urandom(), 4'($urandom_range(1, 15)));
            bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
            bus.avm_readdata    = $urandom();
        end
        apply_wb();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((bus.i_req || bus.d_req || (wb_q.size() > 0)) && (n < budget)) begin
            step();
            n++;
        end
        check({tag, "_pending"}, 32'(int'(bus.i_req) + int'(bus.d_req) + wb_q.size()), 0);
        if (sb_on) check({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int d_n;
        int i_n;

        // reset with every requester asserted
        rst                 = 1'b1;
        bus.i_req           = 1'b1;
        bus.i_addr          = 32'h0000_0100;
        bus.d_req           = 1'b1;
        bus.d_addr          = 32'h0000_0200;
        bus.d_byteenable    = 4'hF;
        bus.avm_readdata    = 32'h0;
        bus.avm_waitrequest = 1'b0;
        for (int k = 0; k < WB_DEPTH; k++) push_wb(32'h0000_0300 + 32'(4 * k), 32'h0, 4'hF);
        apply_wb();
        @(posedge clk);
        #1;
        model_on = 1'b1;
        step();
        check("rst_c1_gs", s_gs, 2'd0);
        check("rst_c1_rw", {s_read, s_write}, 2'b00);
        check("rst_c1_wbwait", s_wbwait, 1'b1);
        rst       = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        wb_q.delete();
        apply_wb();
        step();
        check("rst_c2_gs", s_gs, 2'd0);
        check("rst_c2_rw", {s_read, s_write}, 2'b00);
        check("rst_c2_wbwait", s_wbwait, 1'b1);
        check("rst_c2_acks", {s_iack, s_dack}, 2'b00);

        // single instruction fetch, no wait states
        bus.avm_readdata = 32'h2402_0005;
        issue_i(32'hBFC0_0000);
        exp_q.push_back({2'd3, 32'hBFC0_0000});
        step();
        check("fetch_sample_gs", s_gs, 2'd0);
        check("fetch_sample_read", s_read, 1'b0);
        step();
        check("fetch_read", s_read, 1'b1);
        check("fetch_ack", s_iack, 1'b1);
        check("fetch_rdata", s_irdata, 32'h2402_0005);
        check("fetch_addr", s_addr, 32'hBFC0_0000);
        drain("fetch", 10);

        // data and instruction contend continuously
        bus.avm_readdata = 32'h1234_5678;
        issue_d(32'h0000_1000, 4'hF);
        issue_i(32'h0000_2000);
        d_n = 1;
        i_n = 1;
`ifdef MIPS_ARB_RR_EN
        exp_q.push_back({2'd2, 32'h0000_1000});
        exp_q.push_back({2'd3, 32'h0000_2000});
        exp_q.push_back({2'd2, 32'h0000_1004});
        exp_q.push_back({2'd3, 32'h0000_2004});
        exp_q.push_back({2'd2, 32'h0000_1008});
        exp_q.push_back({2'd2, 32'h0000_100C});
`else
        exp_q.push_back({2'd2, 32'h0000_1000});
        exp_q.push_back({2'd2, 32'h0000_1004});
        exp_q.push_back({2'd2, 32'h0000_1008});
        exp_q.push_back({2'd2, 32'h0000_100C});
        exp_q.push_back({2'd3, 32'h0000_2000});
        exp_q.push_back({2'd3, 32'h0000_2004});
`endif
        for (int c = 0; (c < 40) && (bus.i_req || bus.d_req); c++) begin
            step();
            if (s_dack && (d_n < 4)) begin
                issue_d(32'h0000_1000 + 32'(4 * d_n), 4'hF);
                d_n++;
            end
            if (s_iack && (i_n < 2)) begin
                issue_i(32'h0000_2000 + 32'(4 * i_n));
                i_n++;
            end
        end
        drain("contention", 5);

        // read-after-write: data waits for the buffer to empty, fetch beats a non-full buffer
        bus.avm_readdata = 32'hCAFE_0001;
        push_wb(32'h0000_3000, 32'hAAAA_0001, 4'hF);
        push_wb(32'h0000_3010, 32'hAAAA_0002, 4'h3);
        apply_wb();
        issue_d(32'h0000_4000, 4'h6);
        issue_i(32'h0000_5000);
        exp_q.push_back({2'd3, 32'h0000_5000});
        exp_q.push_back({2'd1, 32'h0000_3000});
        exp_q.push_back({2'd1, 32'h0000_3010});
        exp_q.push_back({2'd2, 32'h0000_4000});
        drain("ordering", 40);

        // full buffer beats both reads and holds through a 3-cycle stall
        for (int k = 0; k < WB_DEPTH; k++) push_wb(32'h0000_6000 + 32'(4 * k), 32'hBB00_0000 + 32'(k), 4'hF);
        apply_wb();
        issue_i(32'h0000_7000);
        issue_d(32'h0000_8000, 4'hF);
        bus.avm_waitrequest = 1'b1;
        exp_q.push_back({2'd1, 32'h0000_6000});
        exp_q.push_back({2'd3, 32'h0000_7000});
        exp_q.push_back({2'd1, 32'h0000_6004});
        exp_q.push_back({2'd1, 32'h0000_6008});
        exp_q.push_back({2'd1, 32'h0000_600C});
        exp_q.push_back({2'd2, 32'h0000_8000});
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("full_stall_gs", s_gs, 2'd1);
            check("full_stall_wbwait", s_wbwait, 1'b1);
            check("full_stall_write", s_write, 1'b1);
        end
        bus.avm_waitrequest = 1'b0;
        step();
        check("full_done_wbwait", s_wbwait, 1'b0);
        check("full_done_addr", s_addr, 32'h0000_6000);
        drain("full", 40);

        // buffer empties while granted: release without writing
        push_wb(32'h0000_9000, 32'hDDDD_0001, 4'hF);
        apply_wb();
        bus.avm_waitrequest = 1'b1;
        step();
        step();
        check("wbdrop_granted", s_gs, 2'd1);
        wb_q.delete();
        apply_wb();
        step();
        check("wbdrop_write", s_write, 1'b0);
        check("wbdrop_wbwait", s_wbwait, 1'b1);
        step();
        check("wbdrop_idle", s_gs, 2'd0);
        bus.avm_waitrequest = 1'b0;

        // reset in the middle of a stalled data read
        bus.avm_waitrequest = 1'b1;
        issue_d(32'h0000_A000, 4'hF);
        step();
        step();
        check("rstmid_granted", s_gs, 2'd2);
        rst = 1'b1;
        step();
        check("rstmid_no_ack", s_dack, 1'b0);
        rst       = 1'b0;
        bus.d_req = 1'b0;
        step();
        check("rstmid_gs", s_gs, 2'd0);
        check("rstmid_read", s_read, 1'b0);
        check("rstmid_ack", s_dack, 1'b0);
        bus.avm_waitrequest = 1'b0;

        // random traffic against the cycle model
        sb_on       = 1'b0;
        random_mode = 1'b1;
        repeat (1500) step();
        random_mode         = 1'b0;
        bus.avm_waitrequest = 1'b0;
        drain("random", 100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have instruction port: i_req in 1 read request; i_addr in 32 word address; i_rdata out 32 read data; i_ack out 1 completion.
REQ-003 SHALL have data port: d_req in 1 read request; d_addr in 32; d_byteenable in 4; d_rdata out 32; d_ack out 1 completion.
REQ-004 SHALL have write-buffer port: wb_write in 1; wb_addr in 32; wb_wdata in 32; wb_byteenable in 4; wb_empty in 1; wb_full in 1; wb_waitrequest out 1.
REQ-005 SHALL have Avalon master: avm_address out 32; avm_read out 1; avm_write out 1; avm_writedata out 32; avm_byteenable out 4; avm_readdata in 32; avm_waitrequest in 1.
REQ-006 SHALL have grant_state out 2 (debug): 0 IDLE, 1 GNT_WB, 2 GNT_D, 3 GNT_I.

Function
REQ-007 SHALL implement FSM {IDLE, GNT_WB, GNT_D, GNT_I}; grants change only from IDLE.
REQ-008 SHALL, in IDLE, select in priority: (1) wb_write and wb_full -> GNT_WB; (2) d_req and wb_empty -> GNT_D; (3) i_req -> GNT_I; (4) wb_write -> GNT_WB; none -> stay IDLE.
REQ-009 SHALL never grant d_req while wb_empty=0 (read-after-write ordering); rule (4) drains the buffer so d_req cannot starve.
REQ-010 SHALL, in a grant state, drive avm_address/avm_byteenable/avm_writedata combinationally from the granted port; i-port byteenable is 4'hF; writedata 0 for reads.
REQ-011 SHALL assert avm_read only in GNT_D/GNT_I, avm_write = wb_write only in GNT_WB; both 0 in IDLE.
REQ-012 SHALL complete a transaction in the cycle avm_read or avm_write is high and avm_waitrequest=0; next state IDLE.
REQ-013 SHALL assert i_ack/d_ack combinationally in the completion cycle only, with i_rdata/d_rdata = avm_readdata that cycle; rdata 0 otherwise.
REQ-014 SHALL drive wb_waitrequest = 0 only in GNT_WB completion cycle, else 1.
REQ-015 SHALL give minimum latency: request sampled in IDLE at cycle N, command at N+1, ack at N+1 if no wait; one IDLE cycle between back-to-back transactions.
REQ-016 SHALL hold grant through arbitrary avm_waitrequest stalls; no timeout.
REQ-017 Requesters SHALL hold req/addr/data stable until ack; arbiter behaviour otherwise undefined and bench SHALL not violate.
REQ-018 SHALL, if wb_write drops in GNT_WB (buffer empty), return to IDLE next cycle with avm_write=0.

Reset
REQ-019 SHALL, on rst, enter IDLE next edge; all outputs 0 except wb_waitrequest=1; RR pointer cleared to favour data.
REQ-020 SHALL, on rst mid-transaction, abandon it: avm_read/avm_write 0 from the cycle after rst is sampled; no ack issued.

Configuration
REQ-021 SHALL support macro MIPS_ARB_RR_EN.
REQ-022 With MIPS_ARB_RR_EN defined: rules (2)/(3) tie (both eligible) resolved round-robin, last-granted read port losing; one-bit pointer updated on each read completion.
REQ-023 Without MIPS_ARB_RR_EN: fixed priority, data over instruction; no pointer register.

Verification
REQ-024 Reset: rst=1 two cycles with all reqs high -> grant_state=0, avm_read=avm_write=0, wb_waitrequest=1.
REQ-025 Single fetch: i_req=1, i_addr=0xBFC00000, avm_waitrequest=0, avm_readdata=0x24020005 -> avm_read next cycle, i_ack=1 same cycle, i_rdata=0x24020005.
REQ-026 Ordering: wb_empty=0, wb_write=1, d_req=1 -> GNT_WB first; d granted only after wb_empty=1; avm_address sequence matches.
REQ-027 Full priority: wb_full=1 with i_req=d_req=1 -> GNT_WB; avm_waitrequest held 3 cycles -> wb_waitrequest=0 only on 4th cycle.
REQ-028 Contention: i_req=d_req=1 held, wb_empty=1 -> without macro d always wins until d_req drops; with MIPS_ARB_RR_EN grants alternate D,I,D,I.
REQ-029 Reset mid-read: rst during GNT_D with avm_waitrequest=1 -> next cycle IDLE, avm_read=0, d_ack never asserted.
